// File: rtl/sysid_verify_pkg.sv
// sysid_verify_pkg: shared state encodings and register map for the sysid boot checker
package sysid_verify_pkg;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_ID = 3'd1;
  localparam logic [2:0] RD_TS = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CAP_ID = 2'd1;
  localparam logic [1:0] ADDR_CAP_TS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;
  localparam int ST_DONE    = 0;
  localparam int ST_PASS    = 1;
  localparam int ST_ID_MIS  = 2;
  localparam int ST_TS_MIS  = 3;
  localparam int ST_TIMEOUT = 4;
  localparam int ST_BUSY    = 5;
endpackage

// File: rtl/sysid_verify_ctrl_if.sv
// sysid_verify_ctrl_if: Avalon-MM bus bundle used for both the sysid master and status slave sides
interface sysid_verify_ctrl_if #(parameter int AW = 1);
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          waitrequest;
  modport master (output address, read, write, writedata, input readdata, waitrequest);
  modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/sysid_verify_ctrl.sv
// sysid_verify_ctrl: reads sysid words 0/1 after boot, compares against expected values, reports status
module sysid_verify_ctrl
  import sysid_verify_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1457892667,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  sysid_verify_ctrl_if.master m,
  sysid_verify_ctrl_if.slave  s,
  output logic                done,
  output logic                pass
);
  logic [2:0]  state;
  logic [15:0] cnt;
  logic [31:0] cap_id, cap_ts, status;
  logic id_mis, ts_mis, timeout, auto_pend;
  logic busy, start, stall, accept, expire;
  logic unused_s;
  assign busy   = state == RD_ID || state == RD_TS || state == CHECK;
  assign start  = !busy && (auto_pend || (s.write && s.address == ADDR_CTRL && s.writedata[0]));
  assign stall  = m.read && m.waitrequest;
  assign accept = m.read && !m.waitrequest;
  assign expire = stall && cnt == 16'(TIMEOUT_CYCLES - 1);
  // Read strobe decoded from state so it drops the instant reset asserts
  assign m.read      = state == RD_ID || state == RD_TS;
  assign m.address   = state == RD_TS;
  assign m.write     = 1'b0;
  assign m.writedata = '0;
  assign s.waitrequest = 1'b0;
  assign unused_s = &{1'b0, s.read, s.writedata[31:1]};
  always_comb begin
    status             = '0;
    status[ST_DONE]    = done;
    status[ST_PASS]    = pass;
    status[ST_ID_MIS]  = id_mis;
    status[ST_TS_MIS]  = ts_mis;
    status[ST_TIMEOUT] = timeout;
    status[ST_BUSY]    = busy;
    s.readdata = s.address == ADDR_STATUS ? status :
                 s.address == ADDR_CAP_ID ? cap_id :
                 s.address == ADDR_CAP_TS ? cap_ts : '0;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_id    <= '0;
      cap_ts    <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      id_mis    <= 1'b0;
      ts_mis    <= 1'b0;
      timeout   <= 1'b0;
      auto_pend <= AUTO_START;
    end else begin
      auto_pend <= 1'b0;
      if (start) begin
        state   <= RD_ID;
        cnt     <= '0;
        done    <= 1'b0;
        pass    <= 1'b0;
        id_mis  <= 1'b0;
        ts_mis  <= 1'b0;
        timeout <= 1'b0;
      end else if (expire) begin
        state   <= DONE;
        timeout <= 1'b1;
        done    <= 1'b1;
        pass    <= 1'b0;
      end else if (accept) begin
        cnt <= '0;
        if (state == RD_ID) begin
          cap_id <= m.readdata;
          state  <= RD_TS;
        end else begin
          cap_ts <= m.readdata;
          state  <= CHECK;
        end
      end else if (stall) begin
        cnt <= cnt + 16'd1;
      end else if (state == CHECK) begin
        id_mis <= cap_id != EXPECTED_ID;
        ts_mis <= cap_ts != EXPECTED_TS;
        pass   <= cap_id == EXPECTED_ID && cap_ts == EXPECTED_TS;
        done   <= 1'b1;
        state  <= DONE;
      end
    end
  end
endmodule

// File: tb/tb_sysid_verify_ctrl.sv
// tb_sysid_verify_ctrl: directed checks of the sysid boot checker against a simple sysid model
module tb_sysid_verify_ctrl;
  localparam logic [31:0] TS = 32'd1457892667;
  logic clock = 1'b0;
  logic reset_n;
  logic done, pass;
  logic wr;
  logic [31:0] id_val, ts_val;
  int errors = 0;
  int checks = 0;
  int n;
  sysid_verify_ctrl_if #(.AW(1)) mb ();
  sysid_verify_ctrl_if #(.AW(2)) sb ();
  assign mb.readdata    = mb.address[0] ? ts_val : id_val;
  assign mb.waitrequest = wr;
  sysid_verify_ctrl #(.TIMEOUT_CYCLES(8), .AUTO_START(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .m(mb.master), .s(sb.slave), .done(done), .pass(pass)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    sb.address = a;
    #1;
    check(tag, sb.readdata, exp);
  endtask
  task automatic wr_slave(input logic [1:0] a, input logic [31:0] d);
    sb.write = 1'b1;
    sb.address = a;
    sb.writedata = d;
    tick();
    sb.write = 1'b0;
    sb.writedata = '0;
  endtask
  initial begin
    reset_n = 1'b0;
    wr = 1'b0;
    id_val = 32'd0;
    ts_val = TS;
    sb.address = '0;
    sb.read = 1'b0;
    sb.write = 1'b0;
    sb.writedata = '0;
    #1;
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_pass", {31'b0, pass}, 32'd0);
    check("rst_mread", {31'b0, mb.read}, 32'd0);
    rd(2'd0, 32'h0, "rst_status");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    // auto-start run, zero wait
    tick();
    check("auto_rdid_read", {31'b0, mb.read}, 32'd1);
    check("auto_rdid_addr", {31'b0, mb.address}, 32'd0);
    tick();
    check("auto_rdts_addr", {31'b0, mb.address}, 32'd1);
    tick();
    check("auto_check_read", {31'b0, mb.read}, 32'd0);
    check("auto_check_done", {31'b0, done}, 32'd0);
    tick();
    check("auto_done", {31'b0, done}, 32'd1);
    check("auto_pass", {31'b0, pass}, 32'd1);
    rd(2'd0, 32'h03, "auto_status");
    rd(2'd2, TS, "auto_cap_ts");
    // ID mismatch
    id_val = 32'h5;
    wr_slave(2'd3, 32'd1);
    rd(2'd0, 32'h20, "mis_busy_status");
    repeat (3) tick();
    check("mis_done", {31'b0, done}, 32'd1);
    check("mis_pass", {31'b0, pass}, 32'd0);
    rd(2'd0, 32'h05, "mis_status");
    rd(2'd1, 32'h5, "mis_cap_id");
    // timeout in RD_ID with waitrequest stuck high
    id_val = 32'd0;
    ts_val = 32'hDEADBEEF;
    wr = 1'b1;
    wr_slave(2'd3, 32'd1);
    n = 0;
    while (mb.read && n < 20) begin
      n++;
      tick();
    end
    check("to_read_cycles", n, 32'd8);
    rd(2'd0, 32'h11, "to_status");
    rd(2'd2, TS, "to_cap_ts");
    rd(2'd1, 32'h5, "to_cap_id");
    ts_val = TS;
    // stall one short of the limit: accept wins
    wr_slave(2'd3, 32'd1);
    repeat (7) tick();
    check("edge_still_read", {31'b0, mb.read}, 32'd1);
    wr = 1'b0;
    tick();
    check("edge_rdts_addr", {31'b0, mb.address}, 32'd1);
    repeat (2) tick();
    check("edge_pass", {31'b0, pass}, 32'd1);
    rd(2'd0, 32'h03, "edge_status");
    rd(2'd1, 32'h0, "edge_cap_id");
    // ignored writes while DONE
    wr_slave(2'd0, 32'd1);
    check("ign_addr0_read", {31'b0, mb.read}, 32'd0);
    wr_slave(2'd3, 32'hFFFFFFFE);
    check("ign_bit0_read", {31'b0, mb.read}, 32'd0);
    rd(2'd0, 32'h03, "ign_status");
    // start held while busy is ignored
    id_val = 32'h5;
    sb.write = 1'b1;
    sb.address = 2'd3;
    sb.writedata = 32'd1;
    tick();
    tick();
    sb.write = 1'b0;
    id_val = 32'd0;
    check("busy_rdts_addr", {31'b0, mb.address}, 32'd1);
    repeat (2) tick();
    rd(2'd0, 32'h05, "busy_status");
    tick();
    check("busy_no_rerun", {31'b0, mb.read}, 32'd0);
    rd(2'd0, 32'h05, "busy_status_hold");
    wr_slave(2'd3, 32'd1);
    rd(2'd0, 32'h20, "restart_cleared");
    repeat (3) tick();
    rd(2'd0, 32'h03, "restart_status");
    // reset during RD_TS stall
    wr_slave(2'd3, 32'd1);
    tick();
    wr = 1'b1;
    tick();
    check("rs_stall_read", {31'b0, mb.read}, 32'd1);
    check("rs_stall_addr", {31'b0, mb.address}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rs_read", {31'b0, mb.read}, 32'd0);
    check("rs_done", {31'b0, done}, 32'd0);
    check("rs_pass", {31'b0, pass}, 32'd0);
    rd(2'd0, 32'h0, "rs_status");
    rd(2'd1, 32'h0, "rs_cap_id");
    wr = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) tick();
    check("rerun_not_done", {31'b0, done}, 32'd0);
    tick();
    check("rerun_done", {31'b0, done}, 32'd1);
    check("rerun_pass", {31'b0, pass}, 32'd1);
    rd(2'd0, 32'h03, "rerun_status");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sysid_verify_ctrl.md
Name: sysid_verify_ctrl

Overview:
- Boot-time sequencer for the 1-bit-address system-ID slave: Avalon-MM master that reads word 0 (system ID) then word 1 (build timestamp).
- Compares both words against expected values; flags timeout on a stalled read.
- Reports results on a small Avalon-MM status slave, plus pass/done pins the reset/boot logic can gate on.
- Sits between the system interconnect (master side to sysid) and the CPU data bus (slave side).

Parameters:
- EXPECTED_ID, 32'd0, expected value at sysid address 0.
- EXPECTED_TS, 32'd1457892667, expected value at sysid address 1.
- TIMEOUT_CYCLES, 255, max cycles m_read may stay stalled by waitrequest before abort; legal range 1..65535.
- AUTO_START, 1, 1 = run one check automatically after reset release.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m_address  out  1  sysid word select.
- m_read  out  1  read strobe to sysid.
- m_readdata  in  32  sysid read data.
- m_waitrequest  in  1  stall; data accepted when m_read && !m_waitrequest.
- s_address  in  2  status slave word select.
- s_read  in  1  status slave read.
- s_write  in  1  status slave write.
- s_writedata  in  32  status slave write data.
- s_readdata  out  32  status slave read data, combinational from registers.
- done  out  1  check finished (pass or fail).
- pass  out  1  last check passed.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; m_read=0, m_address=0; done=0, pass=0.
  - All flags and captured words = 0; timeout counter = 0.
- Start sources:
  - Write to s_address 3 with s_writedata[0]=1.
  - If AUTO_START=1, an internal pending-start set by reset and consumed on the first cycle out of reset.
  - Start is ignored while busy (state != IDLE/DONE).
- Start accepted in IDLE/DONE: clear done, pass, all mismatch/timeout flags; go RD_ID next cycle.
- RD_ID:
  - m_read=1, m_address=0.
  - On accept: capture m_readdata into cap_id, clear counter, go RD_TS.
- RD_TS:
  - m_read=1, m_address=1.
  - On accept: capture into cap_ts, go CHECK.
- Timeout:
  - In RD_ID/RD_TS, counter increments each cycle m_waitrequest=1.
  - When the counter reaches TIMEOUT_CYCLES while still stalled: set timeout flag, drop m_read, go DONE with pass=0.
  - Counter resets on entry to each read state.
  - An accept on the same cycle the counter would hit the limit wins: no timeout.
- CHECK (1 cycle):
  - id_mis = cap_id != EXPECTED_ID; ts_mis = cap_ts != EXPECTED_TS.
  - pass = !(id_mis | ts_mis); go DONE.
- DONE: done=1 held; m_read=0; accepts a new start.
- Latency: zero-wait sysid gives start-accept to done=1 in 4 cycles (RD_ID, RD_TS, CHECK, DONE).
- m_read is held continuously with stable m_address until accepted or timed out; never deasserted mid-stall except by timeout or reset.
- Status slave read map:
  - 0: {26'b0, busy, timeout, ts_mis, id_mis, pass, done}.
  - 1: cap_id.
  - 2: cap_ts.
  - 3: 0.
- Slave writes to addresses 0–2 are ignored; s_writedata[31:1] at address 3 is ignored.
- Reset mid-operation: m_read drops immediately on reset assertion; with AUTO_START=1 the check re-runs after release.
- Simultaneous s_write start and internal auto-start: a single run.

Decomposition:
- Package sysid_verify_pkg:
  - State enum (IDLE, RD_ID, RD_TS, CHECK, DONE).
  - Slave address constants (ADDR_STATUS=0, ADDR_CAP_ID=1, ADDR_CAP_TS=2, ADDR_CTRL=3).
  - Status bit index constants.
- No sub-module required; the timeout counter stays inline.

Test Plan:
- Sysid model returns 0 / 1457892667, zero wait, AUTO_START=1 -> after reset release done=1 within 5 cycles; pass=1; status word 0 = 0x03.
- Model returns 0x00000005 at address 0 -> done=1, pass=0, id_mis=1; status word 0 = 0x05; s_address 1 reads 0x00000005.
- waitrequest held high, TIMEOUT_CYCLES=8 -> m_read high exactly 8 cycles then low; status word 0 = 0x11; cap_ts unchanged.
- waitrequest high 7 cycles then low with TIMEOUT_CYCLES=8 -> no timeout; pass=1.
- Write 1 to address 3 while busy -> ignored, single run completes; write again after done -> flags clear, fresh run passes.
- Assert reset_n=0 during RD_TS stall -> m_read=0 same cycle, all outputs 0; after release the check re-runs and passes.
